// File: rtl/unit_in_tx_pkg.sv
// Shared definitions for the unit input transmitter: data width and FSM state type.
package unit_in_tx_pkg;

  localparam int unsigned UNIT_INPUT_WIDTH = 64;
  localparam int unsigned CNT_WIDTH        = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/unit_in_tx.sv
// Forwards upstream packets into the unit input buffer one word per cycle,
// gated by unit thread availability and almost-full, with length checking.
module unit_in_tx
  import unit_in_tx_pkg::*;
#(
  parameter int unsigned MAX_PKT_WORDS = 64,
  parameter int unsigned MIN_PKT_WORDS = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [UNIT_INPUT_WIDTH-1:0] din,
  input  logic                        din_last,
  input  logic                        din_valid,
  output logic                        din_ready,
  output logic [UNIT_INPUT_WIDTH-1:0] unit_in,
  output logic                        unit_in_ctrl,
  output logic                        unit_in_wr_en,
  input  logic                        unit_in_afull,
  input  logic                        unit_in_ready,
  output logic                        busy,
  output logic [15:0]                 pkt_sent,
  output logic                        err
);

  localparam logic [CNT_WIDTH:0] MAX_W = (CNT_WIDTH+1)'(MAX_PKT_WORDS);
  localparam logic [CNT_WIDTH:0] MIN_W = (CNT_WIDTH+1)'(MIN_PKT_WORDS);

  state_t               state;
  state_t               state_nxt;
  logic [CNT_WIDTH-1:0] count;
  logic [CNT_WIDTH:0]   count_inc;
  logic                 accept;
  logic                 fwd;
  logic                 pkt_done;
  logic                 len_err;

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    accept    = 1'b0;
    fwd       = 1'b0;
    pkt_done  = 1'b0;
    len_err   = 1'b0;
    count_inc = {1'b0, count} + 1'b1;
    unique case (state)
      IDLE: begin
        if (unit_in_ready && din_valid) state_nxt = SEND;
      end
      SEND: begin
        // unit_in_ready is deliberately ignored here: the unit drops it mid-packet
        din_ready = ~unit_in_afull;
        accept    = din_valid & ~unit_in_afull;
        if (accept) begin
          if (din_last) begin
            fwd = 1'b1;
            if (count_inc >= MIN_W) begin
              pkt_done  = 1'b1;
              state_nxt = IDLE;
            end else begin
              len_err   = 1'b1;
              state_nxt = ERR;
            end
          end else if (count_inc == MAX_W) begin
            // a non-last word in the final slot can never close the packet: drop it
            len_err   = 1'b1;
            state_nxt = ERR;
          end else begin
            fwd = 1'b1;
          end
        end
      end
      ERR: begin
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      unit_in       <= '0;
      unit_in_ctrl  <= 1'b0;
      unit_in_wr_en <= 1'b0;
      count         <= '0;
      pkt_sent      <= '0;
      err           <= 1'b0;
    end else begin
      state         <= state_nxt;
      unit_in_wr_en <= fwd;
      if (fwd) begin
        unit_in      <= din;
        unit_in_ctrl <= din_last;
      end
      if (state != SEND) count <= '0;
      else if (accept)   count <= count_inc[CNT_WIDTH-1:0];
      if (pkt_done) pkt_sent <= pkt_sent + 16'd1;
      if (len_err)  err      <= 1'b1;
    end
  end

  assign busy = (state == SEND);

endmodule

// File: tb/tb_unit_in_tx.sv
// Randomized bench for unit_in_tx: a packet source, random unit flow control,
// and a packet-level reference model predicting every output each cycle.
module tb_unit_in_tx;
  import unit_in_tx_pkg::*;

  localparam int unsigned MAXW     = 64;
  localparam int unsigned MINW     = 2;
  localparam int unsigned N_CYCLES = 8000;
  localparam int unsigned W        = UNIT_INPUT_WIDTH;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [W-1:0]  din;
  logic          din_last;
  logic          din_valid;
  logic          din_ready;
  logic [W-1:0]  unit_in;
  logic          unit_in_ctrl;
  logic          unit_in_wr_en;
  logic          unit_in_afull;
  logic          unit_in_ready;
  logic          busy;
  logic [15:0]   pkt_sent;
  logic          err;

  always #5 CLK = ~CLK;

  unit_in_tx #(.MAX_PKT_WORDS(MAXW), .MIN_PKT_WORDS(MINW)) dut (
    .CLK(CLK), .RESET(RESET), .din(din), .din_last(din_last), .din_valid(din_valid),
    .din_ready(din_ready), .unit_in(unit_in), .unit_in_ctrl(unit_in_ctrl),
    .unit_in_wr_en(unit_in_wr_en), .unit_in_afull(unit_in_afull),
    .unit_in_ready(unit_in_ready), .busy(busy), .pkt_sent(pkt_sent), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // packet source: words waiting to be offered upstream
  logic [W-1:0] src_data[$];
  bit           src_last[$];
  int           gap;

  task automatic new_packet();
    int  len;
    bit  overlong;
    overlong = 0;
    case ($urandom_range(0, 9))
      0:       len = 1;
      1:       begin len = MAXW + 1; overlong = 1; end
      2:       len = MAXW;
      3:       len = MINW;
      default: len = $urandom_range(MINW, 8);
    endcase
    for (int i = 0; i < len; i++) begin
      src_data.push_back({$urandom(), $urandom()});
      src_last.push_back(!overlong && (i == len - 1));
    end
  endtask

  // packet-level view of where the transmitter should be
  typedef enum {M_WAIT, M_STREAM, M_LOCKED} mode_t;
  mode_t        mode;
  int           words;
  int           sent;
  bit           sticky;
  int           lock_wait;
  bit           exp_wr;
  logic [W-1:0] exp_data;
  bit           exp_ctrl;

  task automatic model_reset();
    mode     = M_WAIT;
    words    = 0;
    sent     = 0;
    sticky   = 0;
    exp_wr   = 0;
    exp_data = '0;
    exp_ctrl = 0;
    src_data.delete();
    src_last.delete();
    gap      = $urandom_range(0, 3);
  endtask

  task automatic check_outputs();
    check("wr_en",    unit_in_wr_en, exp_wr);
    check("unit_in",  unit_in, exp_data);
    check("ctrl",     unit_in_ctrl, exp_ctrl);
    check("busy",     busy, mode == M_STREAM);
    check("err",      err, sticky);
    check("pkt_sent", pkt_sent, sent[15:0]);
  endtask

  initial begin
    bit rst;
    int n;
    RESET = 1'b1; din = '0; din_last = 0; din_valid = 0;
    unit_in_afull = 0; unit_in_ready = 0;
    repeat (2) @(posedge CLK);
    model_reset();
    lock_wait = 0;
    #1;
    check_outputs();
    check("rst_din_ready", din_ready, 0);

    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge CLK);
      rst = ($urandom_range(0, 399) == 0);
      if (mode == M_LOCKED) begin
        if (lock_wait == 0) rst = 1;
        else lock_wait--;
      end
      RESET         = rst;
      unit_in_ready = ($urandom_range(0, 9) < 6);
      unit_in_afull = ($urandom_range(0, 9) < 2);
      if (src_data.size() == 0) begin
        if (gap == 0) begin
          new_packet();
          gap = $urandom_range(0, 3);
        end else gap--;
      end
      din_valid = (src_data.size() != 0) && ($urandom_range(0, 9) < 8);
      din       = din_valid ? src_data[0] : {$urandom(), $urandom()};
      din_last  = din_valid ? src_last[0] : 1'($urandom_range(0, 1));
      #1;
      check("din_ready", din_ready, (mode == M_STREAM) && !unit_in_afull);

      @(posedge CLK);
      exp_wr = 0;
      if (RESET) begin
        model_reset();
      end else begin
        case (mode)
          M_WAIT: if (unit_in_ready && din_valid) mode = M_STREAM;
          M_STREAM: begin
            if (din_valid && !unit_in_afull) begin
              void'(src_data.pop_front());
              void'(src_last.pop_front());
              n = words + 1;
              if (din_last) begin
                exp_wr = 1; exp_data = din; exp_ctrl = 1;
                if (n >= MINW) begin
                  sent  = (sent + 1) % 65536;
                  mode  = M_WAIT;
                  words = 0;
                end else begin
                  sticky    = 1;
                  mode      = M_LOCKED;
                  lock_wait = $urandom_range(3, 12);
                end
              end else if (n == MAXW) begin
                sticky    = 1;
                mode      = M_LOCKED;
                lock_wait = $urandom_range(3, 12);
              end else begin
                exp_wr = 1; exp_data = din; exp_ctrl = 0;
                words  = n;
              end
            end
          end
          default: ;
        endcase
      end
      #1;
      check_outputs();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
